// File: rtl/instruction_prefetch_buffer_if.sv
// Fetch-side and decode-side signals of the instruction prefetch buffer.
// The slave modport is the buffer's view; master is the view of whatever drives it.
interface instruction_prefetch_buffer_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WORD_W = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              ihit;
  logic [WORD_W-1:0] iload;
  logic              redirect_en;
  logic [WORD_W-1:0] redirect_pc;
  logic              halt;
  logic              out_ready;
  logic              out_valid;
  logic [WORD_W-1:0] out_instr;
  logic [WORD_W-1:0] out_pc;
  logic [WORD_W-1:0] out_pp4;
  logic [CNT_W-1:0]  count;

  modport slave (
    output iREN, iaddr, out_valid, out_instr, out_pc, out_pp4, count,
    input  ihit, iload, redirect_en, redirect_pc, halt, out_ready
  );

  modport master (
    input  iREN, iaddr, out_valid, out_instr, out_pc, out_pp4, count,
    output ihit, iload, redirect_en, redirect_pc, halt, out_ready
  );
endinterface

// File: rtl/instruction_prefetch_buffer.sv
// Instruction prefetch FIFO: fetches sequential words from instruction memory
// into a DEPTH-entry queue of {pc, instr} and presents the head to decode.
module instruction_prefetch_buffer #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       WORD_W   = 32,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic                               CLK,
  input  logic                               RST,
  instruction_prefetch_buffer_if.slave       bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  logic [0:0]        state;
  logic [WORD_W-1:0] fetch_pc;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic [WORD_W-1:0] pc_mem    [DEPTH];
  logic [WORD_W-1:0] instr_mem [DEPTH];

  logic fetch_en;
  logic push;
  logic pop;
  logic head_valid;

  always_comb begin
    fetch_en   = (state == RUN) && (count < CNT_W'(DEPTH)) && !bus.redirect_en && !RST;
    push       = fetch_en && bus.ihit;
    head_valid = (count != '0) && !RST;
    // A redirect flushes the queue, so a same-cycle pop must not move the head.
    pop        = head_valid && bus.out_ready && !bus.redirect_en;

    bus.iREN      = fetch_en;
    bus.iaddr     = fetch_pc;
    bus.out_valid = head_valid;
    bus.out_instr = instr_mem[head];
    bus.out_pc    = pc_mem[head];
    bus.out_pp4   = pc_mem[head] + WORD_W'(4);
    bus.count     = count;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (bus.redirect_en) begin
      state    <= RUN;
      fetch_pc <= bus.redirect_pc;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (bus.halt)
        state <= HALTED;
      if (push) begin
        fetch_pc <= fetch_pc + WORD_W'(4);
        tail     <= tail + PTR_W'(1);
      end
      if (pop)
        head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[tail]    <= fetch_pc;
      instr_mem[tail] <= bus.iload;
    end
  end

endmodule

// File: doc/instruction_prefetch_buffer.md
INSTRUCTION_PREFETCH_BUFFER -- requirements
Module: instruction_prefetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, prefetch FIFO entries; power of two, 2..16.
REQ-002 Parameter WORD_W, default 32, width of instruction and PC words.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 iREN  out  1  instruction memory read request.
REQ-007 iaddr  out  WORD_W  fetch address (fetch_pc).
REQ-008 ihit  in  1  memory returns valid word this cycle for iaddr.
REQ-009 iload  in  WORD_W  instruction word, valid when ihit.
REQ-010 redirect_en  in  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc  in  WORD_W  new fetch address, valid with redirect_en.
REQ-012 halt  in  1  stop issuing requests (sticky until redirect or reset).
REQ-013 out_ready  in  1  decode stage accepts an instruction this cycle.
REQ-014 out_valid  out  1  FIFO head valid.
REQ-015 out_instr  out  WORD_W  head instruction.
REQ-016 out_pc  out  WORD_W  head address.
REQ-017 out_pp4  out  WORD_W  out_pc + 4, modulo 2^WORD_W.
REQ-018 count  out  clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-019 FSM states RUN, HALTED; reset state RUN.
REQ-020 RUN -> HALTED when halt=1 and redirect_en=0; HALTED -> RUN only on redirect_en=1; redirect_en wins over simultaneous halt.
REQ-021 iREN = (state==RUN) && (count<DEPTH) && !redirect_en && !RST; iaddr = fetch_pc at all times.
REQ-022 Push: iREN && ihit -> write {fetch_pc, iload} at tail, fetch_pc <= fetch_pc+4 (wraps modulo 2^WORD_W), tail pointer wraps mod DEPTH.
REQ-023 ihit with iREN=0 ignored (no push, no PC change).
REQ-024 Pop: out_valid && out_ready -> head pointer advances mod DEPTH; out_* purely from FIFO head, no bypass, so push-to-out_valid latency is 1 cycle.
REQ-025 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-026 Full (count==DEPTH): iREN=0, no push; pop the same cycle frees a slot usable from the next cycle.
REQ-027 Empty (count==0): out_valid=0; out_ready ignored; out_instr/out_pc/out_pp4 hold last head-slot contents (don't-care).
REQ-028 redirect_en=1: next cycle count=0, pointers=0, fetch_pc=redirect_pc, state=RUN; pending ihit and out_ready that cycle discarded.
REQ-029 HALTED: no requests; FIFO continues to drain via out_ready.
REQ-030 count = pushes minus pops since last flush, never exceeds DEPTH nor underflows.

Reset
REQ-031 RST=1 at a rising edge: fetch_pc=RESET_PC, count=0, pointers=0, state=RUN; takes priority over redirect, push, pop.
REQ-032 During RST=1: iREN=0, out_valid=0; RST mid-operation discards all FIFO contents.
REQ-033 First request (iREN=1, iaddr=RESET_PC) in the first cycle after RST deasserts.
REQ-034 FIFO storage array not reset; only control state is.

Verification
REQ-035 Reset then ihit=1 every cycle, out_ready=0, DEPTH=4 -> pushes PC 0,4,8,C; count=4; iREN=0; iaddr=0x10.
REQ-036 From full, out_ready=1 one cycle -> out_pc=0 popped, count 3, next cycle iREN=1 iaddr=0x10.
REQ-037 ihit=1, out_ready=1 continuously -> steady count 1, out_pc sequence 0,4,8,...; out_pp4=out_pc+4.
REQ-038 count=3, redirect_en=1, redirect_pc=0x100, ihit=1 same cycle -> next cycle count=0, out_valid=0, iaddr=0x100; following ihit pushes pc 0x100.
REQ-039 halt=1 with count=2 -> iREN=0 thereafter; two out_ready pops drain to count=0; redirect_en to 0x40 -> RUN, iaddr=0x40.
REQ-040 fetch_pc=0xFFFFFFFC, ihit=1 -> entry pc 0xFFFFFFFC, out_pp4=0, next iaddr=0; RST asserted with count=2 -> count=0, iaddr=RESET_PC.
